// File: rtl/regfile_write_buffer.sv
// Register file write buffer: queues WB-stage writes and drains them one per cycle.
// Pending entries stay visible to decode through a youngest-match forwarding lookup.
module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rf_wr_stall,
  output logic [15:0]       rf_wordline,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [3:0]        fwd_reg,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [3:0]        reg_q [DEPTH];
  logic [3:0]        reg_d [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DATA_W-1:0] dat_d [DEPTH];
  logic [PTR_W-1:0]  fwd_idx;
  logic              push;
  logic              pop;

  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);
  assign wb_ready = !rst && (cnt_q < CNT_W'(DEPTH));
  assign pop      = !empty && !rf_wr_stall;
  // R0 writes complete the handshake but never occupy an entry
  assign push     = wb_valid && wb_ready && (wb_reg != 4'd0);

  always_comb begin
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(push);
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    vld_d  = vld_q;
    reg_d  = reg_q;
    dat_d  = dat_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      reg_d[tail_q] = wb_reg;
      dat_d[tail_q] = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= reg_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_comb begin
    rf_wordline = '0;
    rf_wdata    = '0;
    if (pop) begin
      rf_wordline[reg_q[head_q]] = 1'b1;
      rf_wdata                   = dat_q[head_q];
    end
  end

  // Scan oldest to youngest so the last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (fwd_reg != 4'd0 && vld_q[fwd_idx] &&
          reg_q[fwd_idx] == fwd_reg) begin
        fwd_hit  = 1'b1;
        fwd_data = dat_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench for regfile_write_buffer: directed cases plus random traffic.
// A queue model tracks pending writes; a negedge monitor checks every output.
module tb_regfile_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  wb_reg = '0;
  logic [15:0] wb_data = '0;
  logic        rf_wr_stall = 1'b0;
  logic [15:0] rf_wordline;
  logic [15:0] rf_wdata;
  logic [3:0]  fwd_reg = '0;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [2:0]  count;
  logic        empty;

  ent_t mdl_q[$];
  ent_t exp_q[$];
  int   npass = 0;
  int   ntot  = 0;

  regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_wr_stall(rf_wr_stall),
    .rf_wordline(rf_wordline), .rf_wdata(rf_wdata),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask

  // One cycle: drive inputs, let the edge happen, advance the model
  task automatic cyc(input logic v, input logic [3:0] r,
                     input logic [15:0] d, input logic st,
                     input logic [3:0] fr);
    bit pop_m;
    bit acc_m;
    wb_valid = v; wb_reg = r; wb_data = d;
    rf_wr_stall = st; fwd_reg = fr;
    @(posedge clk);
    if (!rst) begin
      pop_m = (mdl_q.size() != 0) && !st;
      acc_m = v && (mdl_q.size() < DEPTH);
      if (pop_m) void'(mdl_q.pop_front());
      if (acc_m && r != 4'd0) begin
        mdl_q.push_back('{r: r, d: d});
        exp_q.push_back('{r: r, d: d});
      end
    end
    #1;
  endtask

  task automatic drain_all();
    for (int k = 0; k < 20 && mdl_q.size() != 0; k++)
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("drained", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    ent_t        e;
    bit          hit;
    logic [15:0] fd;
    if (!rst) begin
      chk("wb_ready", wb_ready, mdl_q.size() < DEPTH);
      chk("count", count, mdl_q.size());
      chk("empty", empty, mdl_q.size() == 0);
      chk("drain_active", rf_wordline != 0,
          mdl_q.size() != 0 && !rf_wr_stall);
      if (rf_wordline != 0) begin
        chk("onehot", $countones(rf_wordline), 1);
        if (exp_q.size() == 0) begin
          chk("spurious_write", rf_wordline, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wordline", rf_wordline, 16'h1 << e.r);
          chk("wdata", rf_wdata, e.d);
        end
      end else begin
        chk("wdata_idle", rf_wdata, 0);
      end
      hit = 0;
      fd  = '0;
      if (fwd_reg != 0)
        foreach (mdl_q[i])
          if (mdl_q[i].r == fwd_reg) begin
            hit = 1;
            fd  = mdl_q[i].d;
          end
      chk("fwd_hit", fwd_hit, hit);
      chk("fwd_data", fwd_data, fd);
    end
  end

  initial begin
    fwd_reg = 4'd3;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", wb_ready, 0);
    chk("rst_wordline", rf_wordline, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", wb_ready, 1);

    // Single push, next cycle drains R3
    cyc(1'b1, 4'd3, 16'hABCD, 1'b0, 4'd0);
    chk("r3_wordline", rf_wordline, 16'h0008);
    chk("r3_wdata", rf_wdata, 16'hABCD);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("r3_empty", empty, 1);
    chk("r3_idle", rf_wordline, 0);

    // Fill under stall, fifth request refused
    cyc(1'b1, 4'd1, 16'd1, 1'b1, 4'd0);
    cyc(1'b1, 4'd2, 16'd2, 1'b1, 4'd0);
    cyc(1'b1, 4'd4, 16'd4, 1'b1, 4'd0);
    cyc(1'b1, 4'd8, 16'd8, 1'b1, 4'd0);
    chk("full_count", count, 4);
    chk("full_ready", wb_ready, 0);
    cyc(1'b1, 4'd9, 16'd9, 1'b1, 4'd0);
    chk("full_count2", count, 4);
    chk("wl_0002", rf_wordline, 0);
    rf_wr_stall = 1'b0;
    #1 chk("wl_0002b", rf_wordline, 16'h0002);
    drain_all();

    // Forwarding picks the youngest match
    cyc(1'b1, 4'd5, 16'h1111, 1'b1, 4'd0);
    cyc(1'b1, 4'd5, 16'h2222, 1'b1, 4'd5);
    chk("fwd_youngest_hit", fwd_hit, 1);
    chk("fwd_youngest", fwd_data, 16'h2222);
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 4'd6);
    chk("fwd_miss", fwd_hit, 0);
    drain_all();

    // R0 write is swallowed
    cyc(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0);
    chk("r0_count", count, 0);
    chk("r0_fwd", fwd_hit, 0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);

    // Steady state at count 2 with pointer wrap
    cyc(1'b1, 4'd7, 16'h0700, 1'b1, 4'd0);
    cyc(1'b1, 4'd9, 16'h0900, 1'b1, 4'd0);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 4'(1 + i), 16'($urandom), 1'b0, 4'(i));
    chk("steady_count", count, 2);
    drain_all();

    // Asynchronous reset with entries pending
    cyc(1'b1, 4'd2, 16'h0202, 1'b1, 4'd0);
    cyc(1'b1, 4'd3, 16'h0303, 1'b1, 4'd0);
    cyc(1'b1, 4'd4, 16'h0404, 1'b1, 4'd0);
    wb_valid = 1'b0;
    rf_wr_stall = 1'b0;
    #1 chk("pre_rst_wl", rf_wordline, 16'h0004);
    #1 rst = 1'b1;
    #1;
    chk("arst_wordline", rf_wordline, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ready", wb_ready, 0);
    mdl_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd2);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          16'($urandom), $urandom_range(0, 9) < 3,
          4'($urandom_range(0, 15)));
    drain_all();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
